// File: rtl/alu_operand_sequencer.sv
// Sequences operand A/B loads, ALU wait, output capture and result handoff for one ALU operation.
// Latency: res_valid rises ALU_LATENCY+3 edges after acceptance; a result is held in RESULT until res_ready.
`ifndef ALU_OPERAND_SIZE
`define ALU_OPERAND_SIZE 8
`endif

module alu_operand_sequencer #(
    parameter int OPERAND_SIZE = `ALU_OPERAND_SIZE,
    parameter int ALU_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [OPERAND_SIZE-1:0] req_op_a,
    input  logic [OPERAND_SIZE-1:0] req_op_b,
    input  logic [3:0]              req_opcode,
    input  logic                    flush,
    output logic [OPERAND_SIZE-1:0] alu_bus,
    output logic [3:0]              alu_opcode,
    output logic                    en_a,
    output logic                    en_b,
    output logic                    en_out,
    input  logic [OPERAND_SIZE-1:0] alu_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [OPERAND_SIZE-1:0] res_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_CAPTURE,
        S_RESULT
    } state_t;

    localparam logic [3:0] EXEC_INIT = (ALU_LATENCY == 0) ? 4'd0 : 4'(ALU_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [OPERAND_SIZE-1:0] op_a_q, op_a_d;
    logic [OPERAND_SIZE-1:0] op_b_q, op_b_d;
    logic [3:0]              opcode_q, opcode_d;
    // Holds req_ready low until the first edge after reset release.
    logic                    rdy_q, rdy_d;
    logic                    accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= 4'd0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            opcode_q <= opcode_d;
            rdy_q    <= rdy_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) && rdy_q;
    assign accept    = req_valid && req_ready && !flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        opcode_d = opcode_q;
        rdy_d    = 1'b1;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_a_d   = req_op_a;
                        op_b_d   = req_op_b;
                        opcode_d = req_opcode;
                        state_d  = S_LOAD_A;
                    end
                end
                S_LOAD_A: state_d = S_LOAD_B;
                S_LOAD_B: begin
                    if (ALU_LATENCY == 0) begin
                        state_d = S_CAPTURE;
                    end else begin
                        state_d = S_EXEC;
                        cnt_d   = EXEC_INIT;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == 4'd0) begin
                        state_d = S_CAPTURE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_CAPTURE: state_d = S_RESULT;
                S_RESULT: begin
                    if (res_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        alu_bus    = '0;
        alu_opcode = 4'd0;
        en_a       = 1'b0;
        en_b       = 1'b0;
        en_out     = 1'b0;
        res_valid  = 1'b0;
        res_data   = '0;
        case (state_q)
            S_LOAD_A: begin
                alu_bus    = op_a_q;
                alu_opcode = opcode_q;
                en_a       = 1'b1;
            end
            S_LOAD_B: begin
                alu_bus    = op_b_q;
                alu_opcode = opcode_q;
                en_b       = 1'b1;
            end
            S_EXEC: alu_opcode = opcode_q;
            S_CAPTURE: begin
                alu_opcode = opcode_q;
                en_out     = 1'b1;
            end
            S_RESULT: begin
                alu_opcode = opcode_q;
                res_valid  = 1'b1;
                res_data   = alu_result;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: three builds (ALU_LATENCY 1, 0, 5) checked against a timeline model each cycle.
module tb_alu_operand_sequencer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        req_valid, req_ready, flush, en_a, en_b, en_out, res_valid, res_ready;
    logic [2:0][W-1:0] op_a, op_b, bus, alu_result, res_data;
    logic [2:0][3:0]   opc, alu_opc;

    int tests = 0;
    int fails = 0;

    function automatic int lat(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 5);
    endfunction

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        case (op)
            4'd3:    return a + b;
            4'd0:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h, want %h (t=%0t)", name, i, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        alu_operand_sequencer #(
            .OPERAND_SIZE(W),
            .ALU_LATENCY((g == 0) ? 1 : ((g == 1) ? 0 : 5))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_op_a  (op_a[g]),
            .req_op_b  (op_b[g]),
            .req_opcode(opc[g]),
            .flush     (flush[g]),
            .alu_bus   (bus[g]),
            .alu_opcode(alu_opc[g]),
            .en_a      (en_a[g]),
            .en_b      (en_b[g]),
            .en_out    (en_out[g]),
            .alu_result(alu_result[g]),
            .res_valid (res_valid[g]),
            .res_ready (res_ready[g]),
            .res_data  (res_data[g])
        );
    end

    // ALU stand-in: A/B input registers and an output register, all fed from the shared bus.
    logic [2:0][W-1:0] ra, rb;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra <= '0;
            rb <= '0;
            alu_result <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (en_a[i]) ra[i] <= bus[i];
                if (en_b[i]) rb[i] <= bus[i];
                if (en_out[i]) alu_result[i] <= alu_f(ra[i], rb[i], alu_opc[i]);
            end
        end
    end

    // Model: ph = cycles since acceptance (0 = idle); RESULT is ph == lat+4.
    int         ph[3];
    logic [W-1:0] ma[3], mb[3];
    logic [3:0] mop[3];
    logic       rdy_seen;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_seen <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                ph[i] <= 0;
                ma[i] <= '0;
                mb[i] <= '0;
                mop[i] <= '0;
            end
        end else begin
            rdy_seen <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (flush[i]) begin
                    ph[i] <= 0;
                end else if (ph[i] == 0) begin
                    if (req_valid[i] && rdy_seen) begin
                        ma[i]  <= op_a[i];
                        mb[i]  <= op_b[i];
                        mop[i] <= opc[i];
                        ph[i]  <= 1;
                    end
                end else if (ph[i] < lat(i) + 4) begin
                    ph[i] <= ph[i] + 1;
                end else if (res_ready[i]) begin
                    ph[i] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("req_ready", i, 32'(req_ready[i]), 32'((ph[i] == 0) && rdy_seen));
            chk("alu_bus", i, 32'(bus[i]), 32'((ph[i] == 1) ? ma[i] : ((ph[i] == 2) ? mb[i] : '0)));
            chk("alu_opcode", i, 32'(alu_opc[i]), 32'((ph[i] > 0) ? mop[i] : 4'd0));
            chk("en_a", i, 32'(en_a[i]), 32'(ph[i] == 1));
            chk("en_b", i, 32'(en_b[i]), 32'(ph[i] == 2));
            chk("en_out", i, 32'(en_out[i]), 32'(ph[i] == lat(i) + 3));
            chk("res_valid", i, 32'(res_valid[i]), 32'(ph[i] == lat(i) + 4));
            chk("res_data", i, 32'(res_data[i]),
                32'((ph[i] == lat(i) + 4) ? alu_f(ma[i], mb[i], mop[i]) : '0));
        end
    end

    // Presents one request (caller guarantees IDLE), scrambles inputs afterwards, waits for res_valid.
    task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                        output int n, output logic [W-1:0] d);
        req_valid[i] = 1'b1;
        op_a[i] = a;
        op_b[i] = b;
        opc[i]  = op;
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        op_a[i] = ~a;
        op_b[i] = ~b;
        opc[i]  = ~op;
        chk("first_en_a", i, 32'(en_a[i]), 32'd1);
        chk("first_bus", i, 32'(bus[i]), 32'(a));
        n = 0;
        while (!res_valid[i] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        d = res_data[i];
    endtask

    int n0, n1, n2;
    logic [W-1:0] d0, d1, d2;

    initial begin
        req_valid = '0;
        flush     = '0;
        res_ready = '1;
        op_a = '0;
        op_b = '0;
        opc  = '0;
        #2;
        chk("rst_req_ready", 0, 32'(req_ready), 32'd0);
        chk("rst_res_valid", 0, 32'(res_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("rel_req_ready_pre_edge", 0, 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 chk("rel_req_ready", 0, 32'(req_ready), 32'h7);

        // Basic operation on all three latency builds, res_ready already high.
        fork
            send(0, 8'h12, 8'h34, 4'd3, n0, d0);
            send(1, 8'h5a, 8'h0f, 4'd0, n1, d1);
            send(2, 8'hc3, 8'h3c, 4'd7, n2, d2);
        join
        chk("latency_L1", 0, 32'(n0), 32'd4);
        chk("latency_L0", 1, 32'(n1), 32'd3);
        chk("latency_L5", 2, 32'(n2), 32'd8);
        chk("data_L1", 0, 32'(d0), 32'h46);
        chk("data_L0", 1, 32'(d1), 32'h0a);
        chk("data_L5", 2, 32'(d2), 32'hff);
        @(posedge clk);
        #1;
        chk("after_xfer_ready", 2, 32'(req_ready[2]), 32'd1);
        chk("after_xfer_valid", 2, 32'(res_valid[2]), 32'd0);

        // Back-pressure: result held while a new request waits.
        res_ready[0] = 1'b0;
        send(0, 8'h21, 8'h43, 4'd3, n0, d0);
        chk("hold_first", 0, 32'(d0), 32'h64);
        req_valid[0] = 1'b1;
        op_a[0] = 8'h0d;
        op_b[0] = 8'h07;
        opc[0]  = 4'd0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 0, 32'(res_valid[0]), 32'd1);
            chk("hold_data", 0, 32'(res_data[0]), 32'h64);
            chk("hold_no_en_a", 0, 32'(en_a[0]), 32'd0);
        end
        res_ready[0] = 1'b1;
        @(posedge clk);
        #1 chk("hold_release_idle", 0, 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        chk("pending_accepted", 0, 32'(en_a[0]), 32'd1);
        chk("pending_bus", 0, 32'(bus[0]), 32'h0d);
        n0 = 0;
        while (!res_valid[0] && n0 < 40) begin
            @(posedge clk);
            #1;
            n0++;
        end
        chk("pending_data", 0, 32'(res_data[0]), 32'h05);
        @(posedge clk);
        #1;

        // Flush during EXEC aborts; flush beats acceptance in IDLE.
        req_valid[0] = 1'b1;
        op_a[0] = 8'h77;
        op_b[0] = 8'h11;
        opc[0]  = 4'd3;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 flush[0] = 1'b1;
        @(posedge clk);
        #1;
        flush[0] = 1'b0;
        chk("flush_idle", 0, 32'(req_ready[0]), 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk("flush_no_en_out", 0, 32'(en_out[0]), 32'd0);
            chk("flush_no_valid", 0, 32'(res_valid[0]), 32'd0);
            @(posedge clk);
            #1;
        end
        flush[0] = 1'b1;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        flush[0] = 1'b0;
        req_valid[0] = 1'b0;
        chk("flush_prio_no_accept", 0, 32'(en_a[0]), 32'd0);
        send(0, 8'h10, 8'h20, 4'd3, n0, d0);
        chk("post_flush_latency", 0, 32'(n0), 32'd4);
        chk("post_flush_data", 0, 32'(d0), 32'h30);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of LOAD_B.
        req_valid[0] = 1'b1;
        op_a[0] = 8'haa;
        op_b[0] = 8'hbb;
        opc[0]  = 4'd5;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(posedge clk);
        #1 chk("pre_reset_en_b", 0, 32'(en_b[0]), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("arst_en_b", 0, 32'(en_b[0]), 32'd0);
        chk("arst_bus", 0, 32'(bus[0]), 32'd0);
        chk("arst_opcode", 0, 32'(alu_opc[0]), 32'd0);
        chk("arst_req_ready", 0, 32'(req_ready[0]), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("arst_rel_pre_edge", 0, 32'(req_ready[0]), 32'd0);
        @(posedge clk);
        #1 chk("arst_rel_ready", 0, 32'(req_ready[0]), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk("arst_no_old_bus", 0, 32'(bus[0]), 32'd0);
            chk("arst_no_valid", 0, 32'(res_valid[0]), 32'd0);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Control-side counterpart to the ALU input/output registers.
- Accepts an operation request (two operands plus opcode) over a valid/ready handshake.
- Drives the shared operand bus and the enable lines of the A-input, B-input and output registers in sequence. Waits out the ALU's combinational/pipeline latency, commands the output-register capture, then presents the captured result over a valid/ready handshake.
- Sits between the instruction control unit and the ALU datapath.

Parameters:
- OPERAND_SIZE, default `operand_size, width of operands, bus and result.
- ALU_LATENCY, default 1, number of EXEC cycles between B load and output capture; legal range 0..15.

Ports:
- clk  input  1  system clock, all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op_a  input  OPERAND_SIZE  operand A.
- req_op_b  input  OPERAND_SIZE  operand B.
- req_opcode  input  4  ALU operation code.
- flush  input  1  synchronous abort, active-high.
- alu_bus  output  OPERAND_SIZE  data_in of both ALU input registers.
- alu_opcode  output  4  opcode held to ALU for the whole operation.
- en_a  output  1  enable of the A input register.
- en_b  output  1  enable of the B input register.
- en_out  output  1  enable of the ALU output register.
- alu_result  input  OPERAND_SIZE  data_out of the ALU output register.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- res_data  output  OPERAND_SIZE  result to consumer.

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - State goes to IDLE.
  - alu_bus, alu_opcode, en_a, en_b, en_out, res_valid and res_data are all 0.
  - req_ready is 0 while reset is asserted and 1 from the first clock edge after release.
- Request capture: a request is accepted on a posedge with req_valid=1, req_ready=1. At that edge req_op_a, req_op_b and req_opcode are latched internally. Later input changes have no effect.
- States and outputs (only the listed enable is 1; all others 0):
  - IDLE: req_ready=1; on acceptance go to LOAD_A.
  - LOAD_A: alu_bus=op_a, en_a=1; next state LOAD_B.
  - LOAD_B: alu_bus=op_b, en_b=1. Next state is EXEC with count=ALU_LATENCY-1, or CAPTURE if ALU_LATENCY=0.
  - EXEC: alu_bus=0, all enables 0. Decrement count; go to CAPTURE when count=0.
  - CAPTURE: en_out=1; next state RESULT.
  - RESULT: res_valid=1, res_data=alu_result (sampled live; the output register is stable here). On res_ready=1 go to IDLE.
- alu_opcode equals the latched opcode in every state from LOAD_A through RESULT, and 0 in IDLE.
- Latency: res_valid rises ALU_LATENCY+3 clock edges after the acceptance edge (ALU_LATENCY=1 gives 4 edges).
- req_ready is 0 in every non-IDLE state. Requests presented while busy are neither accepted nor latched.
- res_valid and res_ready both high at the same edge: the transfer completes, the state is IDLE next cycle, and req_ready=1 that cycle. No back-to-back acceptance occurs in the same edge as result transfer.
- res_ready held low: RESULT is held indefinitely with res_valid=1 and res_data stable.
- flush=1 at a posedge in any state: go to IDLE and drop all enables/valid next cycle. No result is produced for the aborted operation. flush has priority over acceptance in IDLE.
- Async reset mid-operation (e.g. in EXEC): immediate IDLE with all outputs zero. The aborted operation never yields res_valid.
- Width: no arithmetic on data paths; the count is 4 bits and never wraps (loaded only from ALU_LATENCY).

Test Plan:
- Reset release, then req_valid with A=0x12, B=0x34, opcode=3, ALU_LATENCY=1 -> en_a for 1 cycle with bus=0x12, then en_b for 1 cycle with bus=0x34, 1 EXEC cycle, en_out for 1 cycle; res_valid 4 edges after accept; res_data equals alu_result model.
- ALU_LATENCY=0 and =5 builds -> res_valid 3 and 8 edges after accept respectively; EXEC cycle count matches.
- Hold res_ready=0 for 10 cycles while a new req_valid is held -> res_valid stays 1 and res_data is constant; req_ready=0 and no second en_a; after res_ready=1, IDLE and the pending request is accepted the following edge.
- res_ready already high when res_valid rises -> single-cycle RESULT; req_ready=1 the next cycle.
- flush asserted during EXEC -> next cycle IDLE, no en_out, no res_valid; then a new request completes normally.
- Async reset pulsed mid-LOAD_B (between edges) -> outputs go to 0 immediately without a clock edge; after release req_ready=1 and the old operands never appear on alu_bus.
